reset_sequencer: RTL and testbench

Multi-stage, parametrised successor to the single-channel MIG reset hold timer. It releases NUM_STAGES downstream reset domains in a fixed order: MIG first, then the clocking-dependent and core domains. Each stage gets its own hold time and an optional ready acknowledge, bounded by a timeout with automatic retry of the whole sequence. It sits at the top level between the board clock/enable logic and every block that needs an ordered power-up release.

---
 rtl/reset_seq_pkg.sv | 10 +
 rtl/reset_seq_counter.sv | 18 +
 rtl/reset_sequencer.sv | 119 +++++++++++
 tb/tb_reset_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding and stage hold-time slice helper for reset_sequencer.
package reset_seq_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, WAIT_ACK, RETRY, DONE, FAULT} state_e;
  localparam int MAX_BITS = 1024;
  function automatic logic [31:0] hold_slice(input logic [MAX_BITS-1:0] vec, input int k, input int w);
    logic [MAX_BITS-1:0] mask;
    mask = (MAX_BITS'(1) << w) - MAX_BITS'(1);
    return 32'((vec >> (k * w)) & mask);
  endfunction
endpackage

// File: rtl/reset_seq_counter.sv
// reset_seq_counter: saturating-by-use up-counter with clear, enable and terminal compare.
module reset_seq_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             hit_o
);
  logic [WIDTH-1:0] count_q;
  assign hit_o = count_q == limit_i;
  always_ff @(posedge clk) begin
    if (rst || clr_i) count_q <= '0;
    else if (en_i) count_q <= count_q + 1'b1;
  end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains in order, with per-stage hold,
// optional ready acknowledge, acknowledge timeout and bounded whole-sequence retry.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                                NUM_STAGES     = 4,
  parameter int                                COUNTER_WIDTH  = 16,
  parameter logic [NUM_STAGES*COUNTER_WIDTH-1:0] STAGE_HOLD   = {NUM_STAGES{COUNTER_WIDTH'(40000)}},
  parameter logic [NUM_STAGES-1:0]             ACK_MASK       = NUM_STAGES'(1),
  parameter int                                TIMEOUT_CYCLES = 60000,
  parameter int                                MAX_RETRIES    = 3,
  localparam int                               RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic [NUM_STAGES-1:0] i_Stage_Ready,
  output logic [NUM_STAGES-1:0] o_Stage_Release,
  output logic                  o_Done,
  output logic                  o_Fault,
  output logic [RW-1:0]         o_Retry_Count
);
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);
  if (COUNTER_WIDTH > 31 || TIMEOUT_CYCLES >= (1 << COUNTER_WIDTH) || NUM_STAGES * COUNTER_WIDTH > MAX_BITS) begin : g_bad_params
    $error("reset_sequencer: TIMEOUT_CYCLES or COUNTER_WIDTH out of range");
  end
  state_e state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [NUM_STAGES-1:0] rel_q, rel_d;
  logic done_q, done_d, fault_q, fault_d, clr, en, adv, hit;
  logic [RW-1:0] retry_q, retry_d;
  logic [COUNTER_WIDTH-1:0] limit;
  assign limit = (state_q == HOLD)
    ? COUNTER_WIDTH'(hold_slice(MAX_BITS'(STAGE_HOLD), int'(stage_q), COUNTER_WIDTH))
    : COUNTER_WIDTH'(TIMEOUT_CYCLES);
  reset_seq_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
    .clk(i_Clock), .rst(i_Reset), .clr_i(clr), .en_i(en), .limit_i(limit), .hit_o(hit)
  );
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    rel_d = rel_q;
    done_d = done_q;
    fault_d = fault_q;
    retry_d = retry_q;
    clr = 1'b0;
    en = 1'b0;
    adv = 1'b0;
    case (state_q)
      IDLE, RETRY: begin
        state_d = HOLD;
        stage_d = '0;
        clr = 1'b1;
      end
      HOLD: begin
        if (hit) begin
          rel_d[stage_q] = 1'b1;
          clr = 1'b1;
          state_d = WAIT_ACK;
          adv = !ACK_MASK[stage_q];
        end else en = 1'b1;
      end
      WAIT_ACK: begin
        clr = 1'b1;
        if (i_Stage_Ready[stage_q]) adv = 1'b1;
        else if (hit) begin
          // the acknowledge check above lets ready on the timeout cycle win
          rel_d = '0;
          state_d = (retry_q == RMAX) ? FAULT : RETRY;
          fault_d = retry_q == RMAX;
          retry_d = (retry_q == RMAX) ? retry_q : retry_q + 1'b1;
        end else begin
          clr = 1'b0;
          en = 1'b1;
        end
      end
      DONE: done_d = 1'b1;
      FAULT: fault_d = 1'b1;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      state_d = (stage_q == LAST) ? DONE : HOLD;
      stage_d = (stage_q == LAST) ? stage_q : stage_q + 1'b1;
    end
    if (!i_Enable) begin
      state_d = IDLE;
      stage_d = '0;
      rel_d = '0;
      done_d = 1'b0;
      fault_d = 1'b0;
      retry_d = '0;
      clr = 1'b1;
      en = 1'b0;
    end
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      rel_q <= '0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rel_q <= rel_d;
      done_q <= done_d;
      fault_q <= fault_d;
      retry_q <= retry_d;
    end
  end
  assign o_Stage_Release = rel_q;
  assign o_Done = done_q;
  assign o_Fault = fault_q;
  assign o_Retry_Count = retry_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table-driven per-edge vectors for a 3-stage sequencer (holds 4,2,0; stage 0 acked).
module tb_reset_sequencer;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [2:0] rdy = '0, rel;
  logic done, fault, rc;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  reset_sequencer #(
    .NUM_STAGES(3), .COUNTER_WIDTH(16), .STAGE_HOLD({16'd0, 16'd2, 16'd4}),
    .ACK_MASK(3'b001), .TIMEOUT_CYCLES(8), .MAX_RETRIES(1)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Enable(en), .i_Stage_Ready(rdy),
    .o_Stage_Release(rel), .o_Done(done), .o_Fault(fault), .o_Retry_Count(rc)
  );
  typedef struct {
    string tag;
    logic r, e;
    logic [2:0] y, l;
    logic d, f, c;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(int n, string tag, logic r, logic e, logic [2:0] y,
                              logic [2:0] l, logic d, logic f, logic c);
    vec_t v;
    v = '{tag, r, e, y, l, d, f, c};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction
  task automatic check(string tag, int i, logic [2:0] l, logic d, logic f, logic c);
    total++;
    if ({rel, done, fault, rc} !== {l, d, f, c}) begin
      bad++;
      $display("FAIL %s step %0d: got rel=%b done=%b fault=%b rc=%b, want rel=%b done=%b fault=%b rc=%b",
               tag, i, rel, done, fault, rc, l, d, f, c);
    end
  endtask
  initial begin
    add(2, "reset", 1, 0, 0, 0, 0, 0, 0);
    add(1, "reset_prio", 1, 1, 0, 0, 0, 0, 0);
    add(1, "rst", 1, 0, 0, 0, 0, 0, 0);
    add(5, "nom_hold0", 0, 1, 0, 3'b000, 0, 0, 0);
    add(3, "nom_wait0", 0, 1, 0, 3'b001, 0, 0, 0);
    add(3, "nom_hold1", 0, 1, 3'b001, 3'b001, 0, 0, 0);
    add(1, "nom_rel1", 0, 1, 3'b001, 3'b011, 0, 0, 0);
    add(1, "nom_rel2", 0, 1, 3'b001, 3'b111, 0, 0, 0);
    add(1, "nom_done", 0, 1, 3'b001, 3'b111, 1, 0, 0);
    add(3, "done_sticky", 0, 1, 3'b000, 3'b111, 1, 0, 0);
    add(1, "rst", 1, 0, 0, 0, 0, 0, 0);
    add(5, "to_hold0", 0, 1, 0, 3'b000, 0, 0, 0);
    add(9, "to_wait0", 0, 1, 0, 3'b001, 0, 0, 0);
    add(1, "to_retry", 0, 1, 0, 3'b000, 0, 0, 1);
    add(5, "to_rehold", 0, 1, 0, 3'b000, 0, 0, 1);
    add(9, "to_rewait", 0, 1, 0, 3'b001, 0, 0, 1);
    add(1, "to_fault", 0, 1, 0, 3'b000, 0, 1, 1);
    add(3, "fault_sticky", 0, 1, 0, 3'b000, 0, 1, 1);
    add(1, "rst_in_fault", 1, 1, 0, 3'b000, 0, 0, 0);
    add(5, "post_fault_hold", 0, 1, 0, 3'b000, 0, 0, 0);
    add(1, "post_fault_rel", 0, 1, 0, 3'b001, 0, 0, 0);
    add(1, "rst", 1, 0, 0, 0, 0, 0, 0);
    add(5, "sim_hold0", 0, 1, 0, 3'b000, 0, 0, 0);
    add(9, "sim_wait0", 0, 1, 0, 3'b001, 0, 0, 0);
    add(1, "sim_ack", 0, 1, 3'b001, 3'b001, 0, 0, 0);
    add(2, "sim_hold1", 0, 1, 3'b001, 3'b001, 0, 0, 0);
    add(1, "sim_rel1", 0, 1, 3'b001, 3'b011, 0, 0, 0);
    add(1, "sim_rel2", 0, 1, 3'b001, 3'b111, 0, 0, 0);
    add(1, "sim_done", 0, 1, 3'b001, 3'b111, 1, 0, 0);
    add(1, "rst", 1, 0, 0, 0, 0, 0, 0);
    add(5, "ab_hold0", 0, 1, 0, 3'b000, 0, 0, 0);
    add(9, "ab_wait0", 0, 1, 0, 3'b001, 0, 0, 0);
    add(1, "ab_retry", 0, 1, 0, 3'b000, 0, 0, 1);
    add(5, "ab_rehold", 0, 1, 0, 3'b000, 0, 0, 1);
    add(3, "ab_rewait", 0, 1, 0, 3'b001, 0, 0, 1);
    add(1, "ab_drop", 0, 0, 0, 3'b000, 0, 0, 0);
    add(5, "ab_restart", 0, 1, 0, 3'b000, 0, 0, 0);
    add(1, "ab_rel0", 0, 1, 0, 3'b001, 0, 0, 0);
    add(1, "rst", 1, 0, 0, 0, 0, 0, 0);
    add(5, "mh_hold0", 0, 1, 0, 3'b000, 0, 0, 0);
    add(3, "mh_wait0", 0, 1, 0, 3'b001, 0, 0, 0);
    add(2, "mh_hold1", 0, 1, 3'b001, 3'b001, 0, 0, 0);
    add(1, "mh_rst", 1, 1, 3'b001, 3'b000, 0, 0, 0);
    add(5, "mh_restart", 0, 1, 0, 3'b000, 0, 0, 0);
    add(1, "mh_rel0", 0, 1, 0, 3'b001, 0, 0, 0);
    add(1, "rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, "zh_hold0", 0, 1, i[0] ? 3'b100 : 3'b000, 3'b000, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, "zh_wait0", 0, 1, i[0] ? 3'b000 : 3'b100, 3'b001, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, "zh_hold1", 0, 1, i[0] ? 3'b001 : 3'b101, 3'b001, 0, 0, 0);
    add(1, "zh_rel1", 0, 1, 3'b100, 3'b011, 0, 0, 0);
    add(1, "zh_rel2", 0, 1, 3'b000, 3'b111, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, "zh_done", 0, 1, i[0] ? 3'b010 : 3'b100, 3'b111, 1, 0, 0);
    rst = 1'b1;
    en = 1'b0;
    rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", -1, 3'b000, 0, 0, 0);
    rst = 1'b0;
    en = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("expired_wait", -2, 3'b001, 0, 0, 0);
    @(posedge clk);
    #1;
    check("expired_retry", -3, 3'b000, 0, 0, 1);
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      en = tbl[i].e;
      rdy = tbl[i].y;
      @(posedge clk);
      #1;
      check(tbl[i].tag, i, tbl[i].l, tbl[i].d, tbl[i].f, tbl[i].c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
